// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer for a single-issue execution stage.
// Fetches over a req/gnt + in-order rvalid port, buffers responses in a small
// in-order queue, issues one (pc, inst) per cycle and handles redirects from
// execution. A misaligned redirect target parks the block in HALT until reset.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  BOOT  | first cycle after reset, no request issued
//  RUN   | normal fetch / issue, redirects accepted
//  HALT  | misaligned redirect seen; no req/issue, outstanding rvalids absorbed
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pc_v_x,
  input  logic [31:0] pc_x,
  input  logic        stall,
  output logic        inst_v_i,
  output logic [31:0] pc_i,
  output logic [31:0] inst_i,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] L_DEPTH = (CW+1)'(DEPTH);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} state_t;

  state_t          r_state;
  logic [31:0]     r_fetch_pc;
  logic [CW-1:0]   r_live;
  logic [CW-1:0]   r_drop;
  logic [CW-1:0]   r_occ;
  logic            r_misalign;

  // In-flight pc FIFO (written at grant) and issue queue (written at response)
  logic [31:0]     r_pf_pc  [DEPTH];
  logic [AW-1:0]   r_pf_head;
  logic [AW-1:0]   r_pf_tail;
  logic [31:0]     r_q_pc   [DEPTH];
  logic [31:0]     r_q_inst [DEPTH];
  logic [AW-1:0]   r_q_head;
  logic [AW-1:0]   r_q_tail;
  logic [31:0]     r_pc_hold;
  logic [31:0]     r_inst_hold;

  logic            w_redir;
  logic            w_grant;
  logic            w_keep;
  logic            w_has_drop;
  logic            w_has_occ;
  logic [CW:0]     w_occ_live;
  logic [CW:0]     w_live_drop;

  assign w_redir     = pc_v_x && (r_state == ST_RUN);
  assign w_has_drop  = (r_drop != '0);
  assign w_has_occ   = (r_occ != '0);
  assign w_occ_live  = {1'b0, r_occ}  + {1'b0, r_live};
  assign w_live_drop = {1'b0, r_live} + {1'b0, r_drop};

  assign imem_req  = (r_state == ST_RUN) && !pc_v_x &&
                     (w_occ_live < L_DEPTH) && (w_live_drop < L_DEPTH);
  assign imem_addr = r_fetch_pc;
  assign w_grant   = imem_req && imem_gnt;

  // Responses in the redirect cycle belong to the wrong path and are dropped
  assign w_keep    = imem_rvalid && !w_has_drop && !w_redir;

  assign inst_v_i  = w_has_occ && !stall && !pc_v_x && (r_state != ST_HALT);
  assign pc_i      = w_has_occ ? r_q_pc[r_q_head]   : r_pc_hold;
  assign inst_i    = w_has_occ ? r_q_inst[r_q_head] : r_inst_hold;
  assign misalign  = r_misalign;

  // FSM, fetch pc, credit counters and queue pointers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_BOOT;
      r_fetch_pc <= RESET_PC;
      r_live     <= '0;
      r_drop     <= '0;
      r_occ      <= '0;
      r_misalign <= 1'b0;
      r_pf_head  <= '0;
      r_pf_tail  <= '0;
      r_q_head   <= '0;
      r_q_tail   <= '0;
    end else if (w_redir) begin
      // Everything still in flight becomes wrong-path; an rvalid this cycle
      // retires one of them immediately.
      r_live    <= '0;
      r_drop    <= r_drop + r_live - CW'(imem_rvalid);
      r_occ     <= '0;
      r_pf_head <= '0;
      r_pf_tail <= '0;
      r_q_head  <= '0;
      r_q_tail  <= '0;
      if (pc_x[1:0] != 2'b00) begin
        r_state    <= ST_HALT;
        r_misalign <= 1'b1;
      end else begin
        r_fetch_pc <= pc_x;
      end
    end else begin
      if (r_state == ST_BOOT) r_state <= ST_RUN;
      if (w_grant) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
        r_pf_tail  <= r_pf_tail + AW'(1);
      end
      r_live <= r_live + CW'(w_grant) - CW'(w_keep);
      if (imem_rvalid && w_has_drop) r_drop <= r_drop - CW'(1);
      if (w_keep) begin
        r_pf_head <= r_pf_head + AW'(1);
        r_q_tail  <= r_q_tail + AW'(1);
      end
      if (inst_v_i) r_q_head <= r_q_head + AW'(1);
      r_occ <= r_occ + CW'(w_keep) - CW'(inst_v_i);
    end
  end

  // Storage arrays: contents are qualified by the counters, so no reset needed
  always_ff @(posedge clk) begin
    if (w_grant) r_pf_pc[r_pf_tail] <= r_fetch_pc;
    if (w_keep) begin
      r_q_pc[r_q_tail]   <= r_pf_pc[r_pf_head];
      r_q_inst[r_q_tail] <= imem_rdata;
    end
  end

  // Remember the last head so pc_i/inst_i hold while the queue is empty
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc_hold   <= '0;
      r_inst_hold <= '0;
    end else if (w_has_occ) begin
      r_pc_hold   <= r_q_pc[r_q_head];
      r_inst_hold <= r_q_inst[r_q_head];
    end
  end

endmodule
